// File: rtl/psum_split3.sv
// psum_split3: fans one partial-sum stream out to three registered lanes,
// either round-robin (one lane per word) or broadcast (every lane per word).
module psum_split3 #(
    parameter int DATA_BITWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     bcast,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_BITWIDTH-1:0] out0_data,
    output logic [DATA_BITWIDTH-1:0] out1_data,
    output logic [DATA_BITWIDTH-1:0] out2_data,
    output logic                     out0_valid,
    output logic                     out1_valid,
    output logic                     out2_valid,
    input  logic                     out0_ready,
    input  logic                     out1_ready,
    input  logic                     out2_ready,
    output logic [DATA_BITWIDTH-1:0] word_cnt
);

    logic [2:0]                        v_q, v_d;
    logic [2:0][DATA_BITWIDTH-1:0]     d_q, d_d;
    logic [1:0]                        ptr_q, ptr_d;
    logic [DATA_BITWIDTH-1:0]          cnt_q, cnt_d;

    logic [2:0] rdy;
    logic [2:0] free;
    logic [2:0] ptr_oh;
    logic [2:0] load;
    logic       accept;

    assign rdy  = {out2_ready, out1_ready, out0_ready};
    // A full lane still counts as free when its consumer drains it this cycle.
    assign free = ~v_q | rdy;

    always_comb begin
        ptr_oh = 3'b000;
        unique case (ptr_q)
            2'd0:    ptr_oh = 3'b001;
            2'd1:    ptr_oh = 3'b010;
            2'd2:    ptr_oh = 3'b100;
            default: ptr_oh = 3'b000;
        endcase
    end

    assign in_ready = !clr && (bcast ? (&free) : (|(free & ptr_oh)));
    assign accept   = in_valid && in_ready;
    assign load     = accept ? (bcast ? 3'b111 : ptr_oh) : 3'b000;

    always_comb begin
        v_d   = v_q & ~rdy;
        d_d   = d_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (load[i]) begin
                v_d[i] = 1'b1;
                d_d[i] = in_data;
            end
        end
        if (accept) begin
            cnt_d = cnt_q + 1'b1;
            if (!bcast) begin
                ptr_d = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
            end
        end
        if (clr) begin
            v_d   = 3'b000;
            ptr_d = 2'd0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= 3'b000;
            d_q   <= '0;
            ptr_q <= 2'd0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign out0_data  = d_q[0];
    assign out1_data  = d_q[1];
    assign out2_data  = d_q[2];
    assign out0_valid = v_q[0];
    assign out1_valid = v_q[1];
    assign out2_valid = v_q[2];
    assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_psum_split3.sv
// tb_psum_split3: directed scenarios plus a randomized run against a
// lane-array reference model; a 4-bit instance covers the counter wrap.
module tb_psum_split3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, bcast, in_valid, in_ready;
    logic [15:0] in_data;
    logic [15:0] o_data [3];
    logic        o_valid [3];
    logic        rdy [3];
    logic [15:0] word_cnt;

    logic        c4_valid, c4_ready;
    logic [3:0]  c4_data, c4_cnt;
    logic [3:0]  c4_o0, c4_o1, c4_o2;
    logic        c4_v0, c4_v1, c4_v2;

    int checks = 0;
    int errors = 0;

    logic        m_v [3];
    logic [15:0] m_d [3];
    int          m_ptr;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    psum_split3 #(.DATA_BITWIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bcast(bcast),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(o_data[0]), .out1_data(o_data[1]), .out2_data(o_data[2]),
        .out0_valid(o_valid[0]), .out1_valid(o_valid[1]),
        .out2_valid(o_valid[2]),
        .out0_ready(rdy[0]), .out1_ready(rdy[1]), .out2_ready(rdy[2]),
        .word_cnt(word_cnt)
    );

    psum_split3 #(.DATA_BITWIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .bcast(1'b0),
        .in_data(c4_data), .in_valid(c4_valid), .in_ready(c4_ready),
        .out0_data(c4_o0), .out1_data(c4_o1), .out2_data(c4_o2),
        .out0_valid(c4_v0), .out1_valid(c4_v1), .out2_valid(c4_v2),
        .out0_ready(1'b1), .out1_ready(1'b1), .out2_ready(1'b1),
        .word_cnt(c4_cnt)
    );

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 1'b0;
            m_d[i] = 16'h0;
        end
        m_ptr = 0;
        m_cnt = 16'h0;
    endfunction

    function automatic logic model_ready();
        int nfree = 0;
        if (clr) return 1'b0;
        for (int i = 0; i < 3; i++)
            if (!m_v[i] || rdy[i]) nfree++;
        if (bcast) return nfree == 3;
        return !m_v[m_ptr] || rdy[m_ptr];
    endfunction

    // Advance one clock, applying the rules to the model with the inputs
    // that were stable at the edge.
    task automatic tick();
        logic acc;
        acc = in_valid && model_ready();
        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < 3; i++) m_v[i] = 1'b0;
            m_ptr = 0;
            m_cnt = 16'h0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (m_v[i] && rdy[i]) m_v[i] = 1'b0;
            if (acc) begin
                if (bcast) begin
                    for (int i = 0; i < 3; i++) begin
                        m_v[i] = 1'b1;
                        m_d[i] = in_data;
                    end
                end else begin
                    m_v[m_ptr] = 1'b1;
                    m_d[m_ptr] = in_data;
                    m_ptr = (m_ptr + 1) % 3;
                end
                m_cnt = m_cnt + 16'd1;
            end
        end
        #1;
    endtask

    task automatic set_rdy(input logic r0, input logic r1, input logic r2);
        rdy[0] = r0;
        rdy[1] = r1;
        rdy[2] = r2;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_valid[i] !== 1'b0 || o_data[i] !== 16'h0) begin
                errors++;
                $display("FAIL reset_lane%0d valid=%b data=%h want 0/0000",
                         i, o_valid[i], o_data[i]);
            end
        end
        checks++;
        if (word_cnt !== 16'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle cnt=%h rdy=%b want 0000/1",
                     word_cnt, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic test_round_robin();
        int lane;
        bcast = 1'b0;
        set_rdy(1, 1, 1);
        for (int k = 1; k <= 6; k++) begin
            in_data  = 16'(k);
            in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rr_ready word%0d got=%b want 1", k, in_ready);
            end
            tick();
            lane = (k - 1) % 3;
            checks++;
            if (o_valid[lane] !== 1'b1 || o_data[lane] !== 16'(k)) begin
                errors++;
                $display("FAIL rr_lane%0d got=%b/%h want 1/%h",
                         lane, o_valid[lane], o_data[lane], 16'(k));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (word_cnt !== 16'd6) begin
            errors++;
            $display("FAIL rr_cnt got=%0d want 6", word_cnt);
        end
    endtask

    task automatic test_lane_stall();
        logic [15:0] w [4];
        int          dst [4];
        w[0] = 16'h00A0; w[1] = 16'h00A1; w[2] = 16'h00A2; w[3] = 16'h00A3;
        dst[0] = 0; dst[1] = 1; dst[2] = 2; dst[3] = 0;
        bcast = 1'b0;
        set_rdy(1, 0, 1);
        for (int k = 0; k < 4; k++) begin
            in_data  = w[k];
            in_valid = 1'b1;
            tick();
            checks++;
            if (o_valid[dst[k]] !== 1'b1 || o_data[dst[k]] !== w[k]) begin
                errors++;
                $display("FAIL stall_word%0d lane%0d got=%b/%h want 1/%h",
                         k, dst[k], o_valid[dst[k]], o_data[dst[k]], w[k]);
            end
        end
        in_data = 16'h00A4;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_block cyc%0d got=%b want 0", c, in_ready);
            end
            tick();
        end
        checks++;
        if (o_data[1] !== 16'h00A1 || o_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got=%b/%h want 1/00a1",
                     o_valid[1], o_data[1]);
        end
        set_rdy(1, 1, 1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release got=%b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (o_data[1] !== 16'h00A4 || o_valid[1] !== 1'b1
            || word_cnt !== 16'd11) begin
            errors++;
            $display("FAIL stall_passthru got=%b/%h cnt=%0d want 1/00a4 11",
                     o_valid[1], o_data[1], word_cnt);
        end
    endtask

    task automatic test_broadcast();
        bcast = 1'b1;
        set_rdy(1, 1, 1);
        in_data  = 16'hBEEF;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_valid[i] !== 1'b1 || o_data[i] !== 16'hBEEF) begin
                errors++;
                $display("FAIL bcast_lane%0d got=%b/%h want 1/beef",
                         i, o_valid[i], o_data[i]);
            end
        end
        set_rdy(1, 1, 0);
        in_data = 16'h1234;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bcast_block cyc%0d got=%b want 0", c, in_ready);
            end
            tick();
        end
        set_rdy(1, 1, 1);
        checks++;
        if (in_ready !== 1'b1 || o_data[2] !== 16'hBEEF) begin
            errors++;
            $display("FAIL bcast_release rdy=%b d2=%h want 1/beef",
                     in_ready, o_data[2]);
        end
        tick();
        checks++;
        if (o_data[0] !== 16'h1234 || o_data[1] !== 16'h1234
            || o_data[2] !== 16'h1234) begin
            errors++;
            $display("FAIL bcast_second got=%h/%h/%h want 1234",
                     o_data[0], o_data[1], o_data[2]);
        end
        // Pointer sat at lane 2 before the broadcasts; it must still be there.
        bcast   = 1'b0;
        in_data = 16'h0C0C;
        tick();
        in_valid = 1'b0;
        checks++;
        if (o_valid[2] !== 1'b1 || o_data[2] !== 16'h0C0C
            || o_valid[0] !== 1'b0 || o_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL bcast_ptr v=%b%b%b d2=%h want 100/0c0c",
                     o_valid[2], o_valid[1], o_valid[0], o_data[2]);
        end
    endtask

    task automatic test_flush();
        set_rdy(0, 0, 0);
        bcast    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h0111;
        tick();
        in_data  = 16'h0222;
        tick();
        clr     = 1'b1;
        in_data = 16'hDEAD;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready got=%b want 0", in_ready);
        end
        tick();
        clr = 1'b0;
        checks++;
        if (o_valid[0] !== 1'b0 || o_valid[1] !== 1'b0 || o_valid[2] !== 1'b0
            || word_cnt !== 16'h0 || o_data[2] !== 16'h0C0C) begin
            errors++;
            $display("FAIL flush_state v=%b%b%b cnt=%h d2=%h want 000/0/0c0c",
                     o_valid[2], o_valid[1], o_valid[0], word_cnt, o_data[2]);
        end
        set_rdy(1, 1, 1);
        in_data = 16'h0F0F;
        tick();
        in_valid = 1'b0;
        checks++;
        if (o_valid[0] !== 1'b1 || o_data[0] !== 16'h0F0F
            || word_cnt !== 16'd1) begin
            errors++;
            $display("FAIL flush_next got=%b/%h cnt=%0d want 1/0f0f 1",
                     o_valid[0], o_data[0], word_cnt);
        end
    endtask

    task automatic test_async_reset();
        set_rdy(0, 0, 0);
        bcast    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h5A5A;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid[0] !== 1'b0 || o_valid[1] !== 1'b0 || o_valid[2] !== 1'b0
            || o_data[0] !== 16'h0 || o_data[1] !== 16'h0
            || o_data[2] !== 16'h0 || word_cnt !== 16'h0) begin
            errors++;
            $display("FAIL async_reset v=%b%b%b d0=%h cnt=%h want all zero",
                     o_valid[2], o_valid[1], o_valid[0], o_data[0], word_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        bcast = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_release got=%b want 1", in_ready);
        end
    endtask

    task automatic test_counter_wrap();
        for (int k = 1; k <= 17; k++) begin
            c4_data  = 4'(k);
            c4_valid = 1'b1;
            @(posedge clk);
            #1;
            if (k == 16) begin
                checks++;
                if (c4_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap_16 got=%0d want 0", c4_cnt);
                end
            end
            if (k == 17) begin
                checks++;
                if (c4_cnt !== 4'd1) begin
                    errors++;
                    $display("FAIL wrap_17 got=%0d want 1", c4_cnt);
                end
            end
        end
        c4_valid = 1'b0;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            bcast    = ($urandom_range(0, 3) == 0);
            clr      = ($urandom_range(0, 19) == 0);
            in_data  = 16'($urandom);
            for (int i = 0; i < 3; i++) rdy[i] = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_ready cyc%0d got=%b want %b",
                             c, in_ready, model_ready());
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (o_valid[i] !== m_v[i] || o_data[i] !== m_d[i]) begin
                    errors++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL rand_lane%0d cyc%0d got=%b/%h want %b/%h",
                                 i, c, o_valid[i], o_data[i], m_v[i], m_d[i]);
                end
            end
            checks++;
            if (word_cnt !== m_cnt) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL rand_cnt cyc%0d got=%h want %h",
                             c, word_cnt, m_cnt);
            end
        end
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    initial begin
        clr      = 1'b0;
        bcast    = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0;
        c4_valid = 1'b0;
        c4_data  = 4'h0;
        for (int i = 0; i < 3; i++) rdy[i] = 1'b1;
        model_reset();
        test_reset();
        test_round_robin();
        test_lane_stall();
        test_broadcast();
        test_flush();
        test_async_reset();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
